pipe_mux_nw: RTL and testbench
==============================

# pipe_mux_nw

Parametrised, pipelined N-channel by W-bit multiplexer with valid/ready flow control and an optional auto-scan channel sequencer. It supersedes the single-bit combinational 16:1 tree in the datapath selection logic. The block keeps the two-level radix-4 tree structure, with a register after each level. It feeds any downstream consumer that applies backpressure.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (1..64)
- NCH, 16, number of input channels; multiple of 4, range 4..64
- SELW, 4, select width; must satisfy 2**SELW >= NCH

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- in_data  in  NCH*WIDTH  packed channels; channel k = in_data[k*WIDTH +: WIDTH]
- in_valid  in  1  in_data/sel/mode qualify this cycle
- in_ready  out  1  block accepts a beat this cycle
- sel  in  SELW  channel select, used in manual mode
- mode  in  1  0 = manual (use sel), 1 = scan (use internal counter)
- out_data  out  WIDTH  selected channel data
- out_ch  out  SELW  channel index that produced out_data
- out_valid  out  1  out_data/out_ch valid
- out_ready  in  1  downstream accepts

## Operation
- Accept: a beat is accepted when in_valid && in_ready.
- Channel used (ch): sel in manual mode, scan_cnt in scan mode.
- Stage 1 (s1): registers the NCH/4 group results, each chosen by ch[1:0] from its group of 4. Also registers ch and valid bit v1.
- Stage 2 (s2): selects group ch[SELW-1:2] from the s1 group results. Registers out_data, out_ch and out_valid (v2).
- Out-of-range select (ch >= NCH, possible only when NCH < 2**SELW):
  - out_data = 0, out_ch = ch.
  - The beat still flows through the pipeline normally.
- Scan counter scan_cnt (SELW bits):
  - Increments by 1 on each accepted beat in scan mode.
  - After NCH-1 it wraps to 0.
  - Holds its value in manual mode or when no beat is accepted.
  - Mode switches do not clear it.
- Flow control (bubble-collapsing):
  - adv2 = !v2 || out_ready
  - adv1 = !v1 || adv2
  - in_ready = adv1
  - A stage register loads only when its adv is 1. Otherwise it holds data and valid unchanged.
- Beats leave in acceptance order. None are dropped or duplicated.

## Timing
- Reset values:
  - out_data = 0, out_ch = 0, out_valid = 0
  - v1 = 0, all s1 registers = 0
  - scan_cnt = 0
  - in_ready = 1 in the cycle after reset deasserts
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+1. That is 2 cycles from acceptance to output, provided no stall occurs.
- Throughput: 1 beat per cycle when out_ready stays high.
- Stall: with out_ready = 0 and both stages full, in_ready = 0 in the same cycle (a combinational path from out_ready to in_ready). Output data must stay stable while out_valid && !out_ready.
- Simultaneous events: in the same cycle, s2 drains (out_ready = 1), s1 moves to s2 and a new beat enters s1. All occupancy is preserved.
- Reset mid-operation: rst = 1 at an edge clears both valid bits and scan_cnt. In-flight beats are discarded, and out_valid = 0 after that edge.
- Inputs (sel, mode, in_data) are sampled only on the accept edge. Changes on any other cycle have no effect.

## Configuration
- PIPE_MUX_SCAN_EN defined: scan mode and scan_cnt are built as described above.
- PIPE_MUX_SCAN_EN undefined:
  - The mode port remains but is ignored.
  - ch = sel always.
  - No scan counter logic is synthesised.
  - All other behaviour is identical.

## Test plan
- Reset: drive rst = 1 for 2 cycles with in_valid = 1 → out_valid = 0, out_data = 0, out_ch = 0. Then in_ready = 1 on the first cycle after rst drops.
- Manual select (WIDTH = 8, NCH = 16): channel k holds 8'h10+k, sel = 5, one beat → out_data = 8'h15, out_ch = 5, exactly 2 cycles after acceptance.
- Backpressure: stream sel = 0,1,2,3 with out_ready = 0 for 3 cycles → in_ready falls after 2 beats are held and out_data stays 8'h10 while stalled. After out_ready = 1 the beats arrive in order 10, 11, 12, 13 with no loss or duplication.
- Scan wrap (macro defined): mode = 1, 18 consecutive beats → out_ch sequence 0..15, 0, 1. Then switching to mode = 0 and back resumes at 2.
- Out-of-range (NCH = 12, SELW = 4): sel = 13 → out_data = 0, out_ch = 13, out_valid = 1.
- Reset mid-stream: assert rst with both stages full → out_valid = 0 next cycle. No stale beat appears afterwards, and scan restarts at 0.

Source files
------------

// File: rtl/pipe_mux_nw.sv
// pipe_mux_nw: pipelined NCH x WIDTH mux, radix-4 two-level tree with
// a register after each level and valid/ready flow control.
// Ports: clk, rst (sync, active high); in_data/in_valid/in_ready/sel/mode
// in; out_data/out_ch/out_valid out, out_ready in.
// Optional scan sequencer built when PIPE_MUX_SCAN_EN is defined.
module pipe_mux_nw #(
   parameter int WIDTH = 8,
   parameter int NCH   = 16,
   parameter int SELW  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH*WIDTH-1:0]   in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SELW-1:0]        sel,
   input  logic                   mode,
   output logic [WIDTH-1:0]       out_data,
   output logic [SELW-1:0]        out_ch,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int NG = NCH / 4;

   logic                      adv1;
   logic                      adv2;
   logic                      acc;
   logic [SELW-1:0]           ch;

   logic                      v1_q, v1_d;
   logic [SELW-1:0]           ch1_q, ch1_d;
   logic [NG-1:0][WIDTH-1:0]  grp_q, grp_d;

   logic                      v2_q, v2_d;
   logic [SELW-1:0]           och_q, och_d;
   logic [WIDTH-1:0]          od_q, od_d;
   logic [WIDTH-1:0]          lvl2;

   // Bubble-collapsing: a stage may load when empty or when the stage
   // after it is moving, so out_ready reaches in_ready combinationally.
   assign adv2     = !v2_q || out_ready;
   assign adv1     = !v1_q || adv2;
   assign in_ready = adv1;
   assign acc      = in_valid && adv1;

`ifdef PIPE_MUX_SCAN_EN
   logic [SELW-1:0] scan_q, scan_d;

   always_comb begin
      scan_d = scan_q;
      if (acc && mode) begin
         if (scan_q == SELW'(NCH - 1))
            scan_d = '0;
         else
            scan_d = scan_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         scan_q <= '0;
      else
         scan_q <= scan_d;
   end

   assign ch = mode ? scan_q : sel;
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign ch          = sel;
`endif

   // Level 1: each group of four picks its member with ch[1:0].
   // Data only loads on an accepted beat.
   always_comb begin
      v1_d  = v1_q;
      ch1_d = ch1_q;
      grp_d = grp_q;
      if (adv1)
         v1_d = in_valid;
      if (acc) begin
         ch1_d = ch;
         for (int g = 0; g < NG; g++) begin
            for (int j = 0; j < 4; j++) begin
               if (ch[1:0] == 2'(j))
                  grp_d[g] = in_data[(4*g+j)*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Level 2: pick the group by the upper select bits. A group index
   // past the last group (ch >= NCH) matches nothing and yields zero.
   always_comb begin
      lvl2 = '0;
      for (int g = 0; g < NG; g++) begin
         if ((ch1_q >> 2) == SELW'(g))
            lvl2 = grp_q[g];
      end
   end

   always_comb begin
      v2_d  = v2_q;
      och_d = och_q;
      od_d  = od_q;
      if (adv2) begin
         v2_d = v1_q;
         if (v1_q) begin
            och_d = ch1_q;
            od_d  = lvl2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q  <= 1'b0;
         ch1_q <= '0;
         grp_q <= '0;
         v2_q  <= 1'b0;
         och_q <= '0;
         od_q  <= '0;
      end else begin
         v1_q  <= v1_d;
         ch1_q <= ch1_d;
         grp_q <= grp_d;
         v2_q  <= v2_d;
         och_q <= och_d;
         od_q  <= od_d;
      end
   end

   assign out_data  = od_q;
   assign out_ch    = och_q;
   assign out_valid = v2_q;

endmodule

// File: tb/tb_pipe_mux_nw.sv
// tb_pipe_mux_nw: directed scoreboard bench for pipe_mux_nw.
// Main instance NCH=16; a second NCH=12 instance covers out-of-range.
module tb_pipe_mux_nw;

   logic          clk;
   logic          rst;
   logic [127:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    sel;
   logic          mode;
   logic [7:0]    out_data;
   logic [3:0]    out_ch;
   logic          out_valid;
   logic          out_ready;

   logic [95:0]   in_data1;
   logic          in_valid1;
   logic          in_ready1;
   logic [3:0]    sel1;
   logic          mode1;
   logic [7:0]    out_data1;
   logic [3:0]    out_ch1;
   logic          out_valid1;
   logic          out_ready1;

   pipe_mux_nw #(.WIDTH(8), .NCH(16), .SELW(4)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .mode(mode),
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   pipe_mux_nw #(.WIDTH(8), .NCH(12), .SELW(4)) dut12 (
      .clk(clk), .rst(rst),
      .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .sel(sel1), .mode(mode1),
      .out_data(out_data1), .out_ch(out_ch1), .out_valid(out_valid1),
      .out_ready(out_ready1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic [3:0] ch;
      int         cyc;
   } exp_t;

   exp_t       q[$];
   int         vec;
   int         err;
   int         cyc;
   int         npop;
   bit         lat_chk;
   bit         last_acc;
   logic [3:0] mscan;

   function automatic logic [7:0] chval(input logic [3:0] c);
      return 8'h10 + {4'h0, c};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: observe handshakes mid-cycle, then step past the edge.
   task automatic cycle();
      exp_t       e;
      logic [3:0] c;
      @(negedge clk);
      last_acc = 1'b0;
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("spurious_out", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               npop++;
               chk("out_data", {24'd0, out_data}, {24'd0, e.d});
               chk("out_ch", {28'd0, out_ch}, {28'd0, e.ch});
               if (lat_chk)
                  chk("latency", cyc, e.cyc + 2);
            end
         end
         if (in_valid && in_ready) begin
`ifdef PIPE_MUX_SCAN_EN
            c = mode ? mscan : sel;
            if (mode)
               mscan = (mscan == 4'd15) ? 4'd0 : mscan + 4'd1;
`else
            c = sel;
`endif
            q.push_back('{chval(c), c, cyc});
            last_acc = 1'b1;
         end
      end
      @(posedge clk);
      cyc++;
      if (rst) begin
         q.delete();
         mscan = 4'd0;
      end
      #1;
   endtask

   task automatic send(input logic [3:0] s);
      int n;
      in_valid = 1'b1;
      sel      = s;
      n        = 0;
      do begin
         cycle();
         n++;
      end while (!last_acc && n < 20);
      if (!last_acc)
         chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int n;
      in_valid = 1'b0;
      n        = 0;
      while (q.size() != 0 && n < 30) begin
         cycle();
         n++;
      end
      chk("drain_empty", q.size(), 32'd0);
   endtask

   initial begin
      int t0;
      int p0;
      vec     = 0;
      err     = 0;
      cyc     = 0;
      npop    = 0;
      lat_chk = 1'b0;
      mscan   = 4'd0;
      for (int k = 0; k < 16; k++)
         in_data[k*8 +: 8] = 8'(16 + k);
      for (int k = 0; k < 12; k++)
         in_data1[k*8 +: 8] = 8'(160 + k);
      in_valid1  = 1'b0;
      sel1       = 4'd0;
      mode1      = 1'b0;
      out_ready1 = 1'b1;

      // Reset with in_valid held high
      rst       = 1'b1;
      in_valid  = 1'b1;
      sel       = 4'd3;
      mode      = 1'b0;
      out_ready = 1'b1;
      cycle();
      cycle();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_out_ch", {28'd0, out_ch}, 32'd0);
      chk("rst_out_valid12", {31'd0, out_valid1}, 32'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

      // Manual select, latency 2
      lat_chk = 1'b1;
      send(4'd5);
      drain();

      // Backpressure
      lat_chk   = 1'b0;
      out_ready = 1'b0;
      p0        = npop;
      send(4'd0);
      send(4'd1);
      in_valid = 1'b1;
      sel      = 4'd2;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data0", {24'd0, out_data}, 32'h10);
      cycle();
      chk("stall_data1", {24'd0, out_data}, 32'h10);
      chk("stall_in_ready1", {31'd0, in_ready}, 32'd0);
      cycle();
      chk("stall_data2", {24'd0, out_data}, 32'h10);
      out_ready = 1'b1;
      send(4'd2);
      send(4'd3);
      drain();
      chk("bp_beats", npop - p0, 32'd4);

      // Full throughput
      lat_chk = 1'b1;
      t0      = cyc;
      for (int s = 0; s < 8; s++)
         send(4'(s + 8));
      chk("throughput_cycles", cyc - t0, 32'd8);
      drain();

`ifdef PIPE_MUX_SCAN_EN
      // Scan wrap, then manual and back resumes where it was
      mode = 1'b1;
      for (int i = 0; i < 18; i++)
         send(4'd9);
      mode = 1'b0;
      send(4'd7);
      mode = 1'b1;
      send(4'd7);
      drain();
`else
      // Mode is ignored without the scan feature
      mode = 1'b1;
      send(4'd6);
      send(4'd14);
      drain();
`endif

      // Reset with both stages full
      lat_chk   = 1'b0;
      mode      = 1'b0;
      out_ready = 1'b0;
      send(4'd4);
      send(4'd5);
      chk("full_before_rst", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      rst      = 1'b1;
      cycle();
      rst = 1'b0;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      mode      = 1'b1;
      send(4'd9);
      drain();
      mode = 1'b0;
      repeat (4) cycle();

      // Out-of-range on the 12-channel instance
      sel1      = 4'd13;
      in_valid1 = 1'b1;
      chk("oor_in_ready", {31'd0, in_ready1}, 32'd1);
      cycle();
      in_valid1 = 1'b0;
      sel1      = 4'd2;
      cycle();
      chk("oor_valid", {31'd0, out_valid1}, 32'd1);
      chk("oor_data", {24'd0, out_data1}, 32'd0);
      chk("oor_ch", {28'd0, out_ch1}, 32'd13);
      sel1      = 4'd11;
      in_valid1 = 1'b1;
      cycle();
      in_valid1 = 1'b0;
      cycle();
      chk("ch11_valid", {31'd0, out_valid1}, 32'd1);
      chk("ch11_data", {24'd0, out_data1}, 32'hAB);
      chk("ch11_ch", {28'd0, out_ch1}, 32'd11);

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
